hazard_ctrl: RTL

//  Hazard and forwarding controller for the 5-stage MIPS_13 pipeline (IF/D/X/M/WB).

---
 rtl/hazard_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: tracks the X and M
// instructions in a shadow scoreboard and drives stall, flush and forward selects.
module hazard_ctrl #(
   parameter int RA_W  = 5,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             d_valid,
   input  logic [RA_W-1:0]  d_rs,
   input  logic [RA_W-1:0]  d_rt,
   input  logic             d_use_rs,
   input  logic             d_use_rt,
   input  logic             d_store,
   input  logic [RA_W-1:0]  d_dst,
   input  logic             d_reg_write,
   input  logic             d_mem_read,
   input  logic             m_br_taken,
   input  logic             m_jmp,
   output logic             stall,
   output logic             flush_fd,
   output logic             flush_dx,
   output logic             flush_xm,
   output logic             fwdX_rs,
   output logic             fwdX_rt,
   output logic             fwdM_rs,
   output logic             fwdM_rt,
   output logic             fwd_xm_rt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   // state   | meaning
   // RUN     | normal issue
   // LDSTALL | one-cycle bubble behind a load-use hazard
   // FLUSH   | one-cycle squash after a taken branch or jump in M

   typedef enum logic [1:0] {RUN, LDSTALL, FLUSH} state_t;

   typedef struct packed {
      logic            v;
      logic [RA_W-1:0] dst;
      logic            rw;
      logic            ld;
      logic            st;
      logic            st_fwd;
   } slot_t;

   state_t state_q;
   slot_t  x_q, m_q, x_next;

   logic x_haz, m_haz;
   logic x_rs_hit, x_rt_alu_hit, x_rt_any_hit;
   logic m_rs_hit, m_rt_any_hit;
   logic load_use, st_fwd_set, flush, fwd_en;

   assign x_haz = x_q.v & x_q.rw & (x_q.dst != '0);
   assign m_haz = m_q.v & m_q.rw & (m_q.dst != '0);

   assign x_rs_hit     = x_haz & d_use_rs & (x_q.dst == d_rs);
   assign x_rt_alu_hit = x_haz & d_use_rt & (x_q.dst == d_rt);
   assign x_rt_any_hit = x_haz & (d_use_rt | d_store) & (x_q.dst == d_rt);
   assign m_rs_hit     = m_haz & d_use_rs & (m_q.dst == d_rs);
   assign m_rt_any_hit = m_haz & (d_use_rt | d_store) & (m_q.dst == d_rt);

   // A store whose data alone depends on the load proceeds; its data is patched in XM.
   assign load_use   = d_valid & x_q.ld & (x_rs_hit | (x_rt_alu_hit & ~d_store));
   assign st_fwd_set = d_valid & d_store & x_q.ld & x_haz & (x_q.dst == d_rt) & ~x_rs_hit;

   assign flush    = rst & (m_br_taken | m_jmp);
   assign stall    = rst & ~flush & load_use & (state_q != LDSTALL);
   assign flush_fd = flush;
   assign flush_dx = flush;
   assign flush_xm = flush;

   assign fwd_en    = d_valid & ~stall & ~flush;
   assign fwdX_rs   = fwd_en & ~x_q.ld & x_rs_hit;
   assign fwdX_rt   = fwd_en & ~x_q.ld & x_rt_any_hit;
   assign fwdM_rs   = fwd_en & m_rs_hit & ~fwdX_rs;
   assign fwdM_rt   = fwd_en & m_rt_any_hit & ~fwdX_rt;
   assign fwd_xm_rt = ~flush & x_q.v & x_q.st & x_q.st_fwd & m_q.v & m_q.ld;

   always_comb begin
      x_next        = '0;
      x_next.v      = d_valid;
      x_next.dst    = d_dst;
      x_next.rw     = d_reg_write;
      x_next.ld     = d_mem_read;
      x_next.st     = d_store;
      x_next.st_fwd = st_fwd_set & ~stall;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= RUN;
         x_q       <= '0;
         m_q       <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         case (state_q)
            RUN:     state_q <= flush ? FLUSH : (stall ? LDSTALL : RUN);
            LDSTALL: state_q <= flush ? FLUSH : RUN;
            FLUSH:   state_q <= flush ? FLUSH : RUN;
            default: state_q <= RUN;
         endcase

         if (flush) begin
            x_q <= '0;
            m_q <= '0;
         end else if (stall) begin
            x_q <= '0;
            m_q <= x_q;
         end else begin
            x_q <= x_next;
            m_q <= x_q;
         end

         if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
         if (flush && (flush_cnt != '1))
            flush_cnt <= flush_cnt + 1'b1;
      end
   end

endmodule
